float_act_quantizer_seq: RTL and testbench

Multi-cycle, handshaked successor to the single-cycle activation quantizer. It maps an IEEE-754 single-precision activation to an OUT_BITS-wide index relative to a per-transaction float range maximum, using an iterative mantissa divider. It also adds a signed (symmetric) mode, optional round-to-nearest, and saturate/error flags. It sits between the float activation stream and the quantized-index buffer feeding the integer datapath.

---
 rtl/float_act_quantizer_seq.sv | 111 +++++++++++
 tb/tb_float_act_quantizer_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/float_act_quantizer_seq.sv
// float_act_quantizer_seq: handshaked float32 activation -> OUT_BITS index quantizer
// relative to a float range maximum, using a restoring mantissa divider (one bit per cycle).
module float_act_quantizer_seq #(
  parameter int OUT_BITS = 8,
  parameter bit ROUND_NEAREST = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [31:0]         i_max,
  input  logic [31:0]         i_activation,
  input  logic                i_signed,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [OUT_BITS-1:0] o_index,
  output logic                o_sat,
  output logic                o_err
);
  localparam int QW = OUT_BITS + 3;
  localparam int CW = $clog2(QW + 1);
  localparam logic signed [10:0] S_MAX = 11'(OUT_BITS);
  typedef enum logic [1:0] {IDLE, DECODE, DIV, DONE} state_t;
  state_t st, st_n;
  logic [31:0] m_r, a_r;
  logic sgn_r, neg_r;
  logic signed [10:0] s_r, s_d;
  logic [24:0] rem;
  logic [QW-2:0] q;
  logic [QW-1:0] q_n, tr;
  logic [CW-1:0] cnt;
  logic [7:0] ea, em;
  logic [23:0] mm;
  logic m_bad, a_nan, a_inf, special, last, ge, hb, big, sp_sat, sp_err, res_sat;
  logic [OUT_BITS-1:0] lim, sp_idx, mag, res_idx;
  logic [10:0] sh;
  logic [QW:0] val;
  assign ea = a_r[30:23];
  assign em = m_r[30:23];
  assign mm = {1'b1, m_r[22:0]};
  assign m_bad = m_r[31] | (em == 8'd0) | (em == 8'hFF);
  assign a_nan = (ea == 8'hFF) & (a_r[22:0] != 23'd0);
  assign a_inf = (ea == 8'hFF) & (a_r[22:0] == 23'd0);
  assign special = m_bad | (ea == 8'hFF) | (ea == 8'd0);
  assign lim = sgn_r ? {1'b0, {(OUT_BITS-1){1'b1}}} : '1;
  assign s_d = 11'(ea) - 11'(em) + S_MAX - 11'(sgn_r);
  assign sp_idx = (!a_inf || m_bad) ? '0 : !a_r[31] ? lim : sgn_r ? -lim : '0;
  assign sp_sat = a_inf & ~m_bad;
  assign sp_err = m_bad | a_nan;
  // restoring step: remainder stays below 2*Mm, so 25 bits suffice
  assign ge = rem >= {1'b0, mm};
  assign q_n = {q, ge};
  // quotient carries OUT_BITS+2 fraction bits; s positions the binary point
  assign sh = 11'(OUT_BITS + 2) - s_r;
  assign tr = q_n >> sh;
  assign hb = 1'(q_n >> (sh - 11'd1));
  assign val = {1'b0, tr} + (QW+1)'(ROUND_NEAREST & hb);
  assign big = (s_r > S_MAX) | (val > (QW+1)'(lim));
  assign mag = big ? lim : val[OUT_BITS-1:0];
  assign res_idx = (neg_r & ~sgn_r) ? '0 : neg_r ? -mag : mag;
  assign res_sat = big | (neg_r & ~sgn_r);
  assign last = cnt == CW'(QW - 1);
  assign o_ready = st == IDLE;
  assign o_valid = st == DONE;
  always_ff @(posedge clk)
    st <= reset ? IDLE : st_n;
  always_comb begin
    st_n = st;
    case (st)
      IDLE:    st_n = i_valid ? DECODE : IDLE;
      DECODE:  st_n = special ? DONE : DIV;
      DIV:     st_n = last ? DONE : DIV;
      default: st_n = i_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      o_index <= '0;
      o_sat <= 1'b0;
      o_err <= 1'b0;
    end else begin
      if (o_ready && i_valid) begin
        m_r <= i_max;
        a_r <= i_activation;
        sgn_r <= i_signed;
      end
      if (st == DECODE) begin
        rem <= {1'b0, 1'b1, a_r[22:0]};
        q <= '0;
        cnt <= '0;
        s_r <= s_d;
        neg_r <= a_r[31];
        if (special) begin
          o_index <= sp_idx;
          o_sat <= sp_sat;
          o_err <= sp_err;
        end
      end
      if (st == DIV) begin
        rem <= (ge ? rem - {1'b0, mm} : rem) << 1;
        q <= q_n[QW-2:0];
        cnt <= cnt + 1'b1;
        if (last) begin
          o_index <= res_idx;
          o_sat <= res_sat;
          o_err <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_float_act_quantizer_seq.sv
// tb_float_act_quantizer_seq: exact-rational reference model with a per-cycle scoreboard,
// floor and round-nearest instances driven in lockstep.
module tb_float_act_quantizer_seq;
  localparam int OB = 8;
  localparam int L = 1 << OB;
  localparam logic [31:0] M256 = 32'h43800000, M561 = 32'h440C4000;
  logic clk = 1'b0, reset = 1'b1, i_valid = 1'b0, i_signed = 1'b0, i_ready = 1'b1;
  logic [31:0] i_max = '0, i_activation = '0;
  logic o_ready [2], o_valid [2], o_sat [2], o_err [2];
  logic [OB-1:0] o_index [2];
  int checks = 0, failures = 0, edges = 0;
  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;
  for (genvar g = 0; g < 2; g++) begin : dut
    float_act_quantizer_seq #(.OUT_BITS(OB), .ROUND_NEAREST(g)) u (
      .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready[g]),
      .i_max(i_max), .i_activation(i_activation), .i_signed(i_signed),
      .o_valid(o_valid[g]), .i_ready(i_ready), .o_index(o_index[g]),
      .o_sat(o_sat[g]), .o_err(o_err[g]));
  end
  typedef struct packed {logic [OB-1:0] idx; logic sat; logic err; int lat;} exp_t;
  typedef struct {exp_t e0; exp_t e1; int acc;} txn_t;
  typedef struct {logic [31:0] m; logic [31:0] a; logic sg; logic [7:0] idx; logic sat; logic err; int hold;} vec_t;
  txn_t sb [$];
  task automatic ck(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at edge %0d", nm, act, req, edges);
    end
  endtask
  // value |a|*scale/m computed exactly from the float fields as a rational number
  function automatic exp_t model(input logic [31:0] m, input logic [31:0] a, input logic sg, input int rn);
    exp_t r;
    longint ma, mm, v2, v, lim;
    int e;
    r = '0;
    r.lat = OB + 5;
    lim = sg ? L/2 - 1 : L - 1;
    if (m[31] || m[30:23] == 8'd0 || m[30:23] == 8'hFF) begin r.err = 1'b1; r.lat = 2; return r; end
    if (a[30:23] == 8'hFF && a[22:0] != 0) begin r.err = 1'b1; r.lat = 2; return r; end
    if (a[30:23] == 8'd0) begin r.lat = 2; return r; end
    if (a[30:23] == 8'hFF) begin
      r.lat = 2; r.sat = 1'b1;
      r.idx = a[31] ? (sg ? OB'(-lim) : '0) : OB'(lim);
      return r;
    end
    if (a[31] && !sg) begin r.sat = 1'b1; return r; end
    ma = longint'({1'b1, a[22:0]});
    mm = longint'({1'b1, m[22:0]});
    e = int'(a[30:23]) - int'(m[30:23]) + (sg ? OB - 1 : OB) + 1;
    if (e > 20) v2 = 64'd1 << 30;
    else if (e >= 0) v2 = (ma << e) / mm;
    else if (e < -30) v2 = 0;
    else v2 = ma / (mm << -e);
    v = rn != 0 ? (v2 + 1) >>> 1 : v2 >>> 1;
    if (v > lim) begin v = lim; r.sat = 1'b1; end
    r.idx = a[31] ? OB'(-v) : OB'(v);
    return r;
  endfunction
  exp_t ce;
  logic seen = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      seen = 1'b0;
    end else begin
      if (o_valid[0] || o_valid[1]) begin
        if (sb.size() == 0) ck("valid_without_txn", {o_valid[0], o_valid[1]}, 0);
        else begin
          for (int k = 0; k < 2; k++) begin
            ce = k == 0 ? sb[0].e0 : sb[0].e1;
            ck($sformatf("valid[%0d]", k), o_valid[k], 1);
            ck($sformatf("ready_in_done[%0d]", k), o_ready[k], 0);
            ck($sformatf("index[%0d]", k), o_index[k], ce.idx);
            ck($sformatf("sat[%0d]", k), o_sat[k], ce.sat);
            ck($sformatf("err[%0d]", k), o_err[k], ce.err);
          end
          if (!seen) ck("latency", edges - sb[0].acc + 1, sb[0].e0.lat);
          seen = 1'b1;
          if (i_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
      if (i_valid && o_ready[0])
        sb.push_back('{model(i_max, i_activation, i_signed, 0), model(i_max, i_activation, i_signed, 1), edges + 1});
    end
  end
  task automatic run(input vec_t t);
    int n;
    @(posedge clk); #2;
    i_max = t.m; i_activation = t.a; i_signed = t.sg; i_valid = 1'b1; i_ready = t.hold == 0;
    @(posedge clk); #2;
    n = 0;
    while (!o_valid[0] && n < 40) begin
      i_max = $urandom; i_activation = $urandom; i_signed = 1'($urandom);
      @(posedge clk); #2;
      n++;
    end
    i_valid = 1'b0;
    if (n == 40) ck("result_timeout", n, 0);
    repeat (t.hold) begin @(posedge clk); #2; end
    i_ready = 1'b1;
    @(posedge clk); #2;
    ck("idle_after_handshake", o_ready[0], 1);
  endtask
  vec_t vt [20] = '{
    '{M256, 32'h42040000, 1'b0, 8'd33,  1'b0, 1'b0, 0},
    '{M256, 32'h3F000000, 1'b0, 8'd0,   1'b0, 1'b0, 0},
    '{M256, 32'h3F800000, 1'b0, 8'd1,   1'b0, 1'b0, 0},
    '{M256, 32'h437F0000, 1'b0, 8'd255, 1'b0, 1'b0, 0},
    '{M256, 32'h43800000, 1'b0, 8'd255, 1'b1, 1'b0, 0},
    '{M256, 32'h448D5800, 1'b0, 8'd255, 1'b1, 1'b0, 5},
    '{M561, 32'h40400000, 1'b0, 8'd1,   1'b0, 1'b0, 0},
    '{M561, 32'h41000000, 1'b0, 8'd3,   1'b0, 1'b0, 0},
    '{M561, 32'h437F0000, 1'b0, 8'd116, 1'b0, 1'b0, 0},
    '{M561, 32'h43800000, 1'b0, 8'd116, 1'b0, 1'b0, 0},
    '{M561, 32'h43808000, 1'b0, 8'd117, 1'b0, 1'b0, 0},
    '{M561, 32'h00000000, 1'b0, 8'd0,   1'b0, 1'b0, 0},
    '{M561, 32'h40000000, 1'b0, 8'd0,   1'b0, 1'b0, 0},
    '{M256, 32'hC2040000, 1'b1, 8'hF0,  1'b0, 1'b0, 2},
    '{M256, 32'h43960000, 1'b1, 8'd127, 1'b1, 1'b0, 0},
    '{M256, 32'hC3960000, 1'b1, 8'h81,  1'b1, 1'b0, 0},
    '{32'h0, 32'h42040000, 1'b0, 8'd0,  1'b0, 1'b1, 0},
    '{M256, 32'h7FC00000, 1'b0, 8'd0,   1'b0, 1'b1, 0},
    '{M256, 32'h7F800000, 1'b0, 8'd255, 1'b1, 1'b0, 3},
    '{M256, 32'hC2040000, 1'b0, 8'd0,   1'b1, 1'b0, 0}
  };
  initial begin
    exp_t e;
    int ghost;
    ck("rn_model_3", model(M561, 32'h40400000, 1'b0, 1).idx, 1);
    ck("rn_model_2", model(M561, 32'h40000000, 1'b0, 1).idx, 1);
    ck("rn_model_257", model(M561, 32'h43808000, 1'b0, 1).idx, 117);
    ck("rn_model_256", model(M561, 32'h43800000, 1'b0, 1).idx, 117);
    ck("rn_model_half", model(M256, 32'h3F000000, 1'b0, 1).idx, 1);
    ck("lat_model_normal", model(M256, 32'h42040000, 1'b0, 0).lat, 13);
    ck("lat_model_zero", model(M561, 32'h0, 1'b0, 0).lat, 2);
    repeat (2) @(posedge clk);
    #2;
    for (int k = 0; k < 2; k++) begin
      ck("reset_ready", o_ready[k], 1);
      ck("reset_valid", o_valid[k], 0);
      ck("reset_index", o_index[k], 0);
      ck("reset_flags", {o_sat[k], o_err[k]}, 0);
    end
    reset = 1'b0;
    foreach (vt[i]) begin
      e = model(vt[i].m, vt[i].a, vt[i].sg, 0);
      ck($sformatf("model_vec%0d", i), {e.idx, e.sat, e.err}, {vt[i].idx, vt[i].sat, vt[i].err});
      run(vt[i]);
    end
    @(posedge clk); #2;
    i_max = M256; i_activation = 32'h42040000; i_signed = 1'b0; i_valid = 1'b1;
    @(posedge clk); #2;
    i_valid = 1'b0;
    repeat (4) begin @(posedge clk); #2; end
    reset = 1'b1;
    @(posedge clk); #2;
    for (int k = 0; k < 2; k++) begin
      ck("midreset_ready", o_ready[k], 1);
      ck("midreset_valid", o_valid[k], 0);
      ck("midreset_index", o_index[k], 0);
      ck("midreset_flags", {o_sat[k], o_err[k]}, 0);
    end
    reset = 1'b0;
    ghost = 0;
    repeat (25) begin
      @(posedge clk); #2;
      if (o_valid[0] || o_valid[1]) ghost++;
    end
    ck("dropped_result_absent", ghost, 0);
    run(vt[10]);
    run(vt[6]);
    ck("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
